// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - slave-side stand-in for the printhead dual-channel serial ADC.
// Optional ADC_RESP_DITHER_EN adds LFSR noise on the sample LSBs.
module adc_spi_responder #(
    parameter int DATA_W     = 16,
    parameter int LEAD_ZEROS = 2,
    parameter int NOISE_BITS = 2
) (
    input  logic              clk48mhz,
    input  logic              rstn,
    input  logic              adc_clk,
    input  logic              adc_cs,
    input  logic              adc_chsel,
    output logic              adc_dout,
    input  logic [DATA_W-1:0] ch0_value,
    input  logic [DATA_W-1:0] ch1_value,
    output logic              frame_done,
    output logic              frame_abort,
    output logic [15:0]       frame_count
);
    localparam int FRAME_BITS = LEAD_ZEROS + DATA_W;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state_q;
    logic [2:0]              clk_sync_q;
    logic [2:0]              cs_sync_q;
    logic [1:0]              chsel_sync_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic                    dout_q;
    logic                    done_q;
    logic                    abort_q;
    logic [15:0]             frame_count_q;
    logic [15:0]             frame_count_d;
    logic [DATA_W-1:0]       sample_sel;
    logic [DATA_W-1:0]       load_sample;
    logic [FRAME_BITS-1:0]   load_word;
    logic                    clk_fall;
    logic                    cs_fall;
    logic                    cs_rise;
    logic                    frame_ok;

    assign clk_fall      = clk_sync_q[2] & ~clk_sync_q[1];
    assign cs_fall       = cs_sync_q[2] & ~cs_sync_q[1];
    assign cs_rise       = ~cs_sync_q[2] & cs_sync_q[1];
    // A release after the last bit was presented counts as complete even without a trailing fall.
    assign frame_ok      = cs_rise && ((state_q == DONE) ||
                                       (state_q == SHIFT && bit_cnt_q == LAST_BIT));
    assign sample_sel    = chsel_sync_q[1] ? ch1_value : ch0_value;
    assign frame_count_d = frame_count_q + 16'd1;
    assign load_word     = FRAME_BITS'(load_sample);

`ifdef ADC_RESP_DITHER_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d      = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign load_sample = sample_sel ^ DATA_W'(lfsr_q[NOISE_BITS-1:0]);

    always_ff @(posedge clk48mhz or negedge rstn) begin
        if (!rstn) begin
            lfsr_q <= 16'hACE1;
        end else if (frame_ok) begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign load_sample = sample_sel;
`endif

    always_ff @(posedge clk48mhz or negedge rstn) begin
        if (!rstn) begin
            clk_sync_q   <= 3'b111;
            cs_sync_q    <= 3'b111;
            chsel_sync_q <= 2'b00;
        end else begin
            clk_sync_q   <= {clk_sync_q[1:0], adc_clk};
            cs_sync_q    <= {cs_sync_q[1:0], adc_cs};
            chsel_sync_q <= {chsel_sync_q[0], adc_chsel};
        end
    end

    always_ff @(posedge clk48mhz or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            dout_q        <= 1'b0;
            done_q        <= 1'b0;
            abort_q       <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    dout_q <= 1'b0;
                    // A clk fall landing in the same cycle as cs fall is deliberately dropped.
                    if (cs_fall) begin
                        shift_q   <= load_word;
                        bit_cnt_q <= '0;
                        dout_q    <= load_word[FRAME_BITS-1];
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        if (frame_ok) begin
                            done_q        <= 1'b1;
                            frame_count_q <= frame_count_d;
                        end else begin
                            abort_q <= 1'b1;
                        end
                        dout_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (clk_fall) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            dout_q  <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            shift_q   <= shift_q << 1;
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            dout_q    <= shift_q[FRAME_BITS-2];
                        end
                    end
                end
                DONE: begin
                    dout_q <= 1'b0;
                    if (cs_rise) begin
                        done_q        <= 1'b1;
                        frame_count_q <= frame_count_d;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    dout_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign adc_dout    = dout_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;
    assign frame_count = frame_count_q;
endmodule
